// File: rtl/btb_pkg.sv
`default_nettype none
// btb_pkg -- direction-counter encodings and saturating step functions shared by the BTB.  rev 1.0
package btb_pkg;

   localparam logic [1:0] SN = 2'b00;
   localparam logic [1:0] WN = 2'b01;
   localparam logic [1:0] WT = 2'b10;
   localparam logic [1:0] ST = 2'b11;

   localparam logic [1:0] CTR_INIT  = WT;
   localparam logic [1:0] CTR_RESET = WN;

   function automatic logic [1:0] ctr_inc_sat(input logic [1:0] c);
      return (c == ST) ? ST : c + 2'd1;
   endfunction

   function automatic logic [1:0] ctr_dec_sat(input logic [1:0] c);
      return (c == SN) ? SN : c - 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// sat_counter2 -- next state of a 2-bit saturating direction counter.  rev 1.0
module sat_counter2
   import btb_pkg::*;
(
   input  logic [1:0] cur,
   input  logic       taken,
   output logic [1:0] nxt
);

   assign nxt = taken ? ctr_inc_sat(cur) : ctr_dec_sat(cur);

endmodule
`default_nettype wire

// File: rtl/btb_predictor.sv
`default_nettype none
// btb_predictor -- direct-mapped BTB with 2-bit direction counters, ID-stage
// update path, mispredict report and saturating hit/mispredict statistics.  rev 1.0
module btb_predictor
   import btb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int INDEX_W = 4,
   parameter int STAT_W  = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] IF_PC,
   output logic              Pred_hit,
   output logic              Pred_taken,
   output logic [ADDR_W-1:0] Pred_target,
   input  logic              Upd_valid,
   input  logic [ADDR_W-1:0] Upd_pc,
   input  logic              Upd_taken,
   input  logic [ADDR_W-1:0] Upd_target,
   input  logic              Upd_pred_taken,
   input  logic [ADDR_W-1:0] Upd_pred_target,
   output logic              Mispredict,
   input  logic              Flush_all,
   output logic [STAT_W-1:0] Hit_cnt,
   output logic [STAT_W-1:0] Mispred_cnt
);

   localparam int ENTRIES = 2**INDEX_W;
   localparam int TAG_W   = ADDR_W - INDEX_W - 2;

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem    [ENTRIES];
   logic [ADDR_W-1:0]  target_mem [ENTRIES];
   logic [1:0]         ctr_mem    [ENTRIES];

   logic [INDEX_W-1:0] lk_idx;
   logic [TAG_W-1:0]   lk_tag;
   logic [INDEX_W-1:0] up_idx;
   logic [TAG_W-1:0]   up_tag;
   logic               up_hit;
   logic [1:0]         ctr_nxt;
   logic               unused_lsbs;

   // Byte offset within the word never reaches the table.
   assign unused_lsbs = ^{IF_PC[1:0], Upd_pc[1:0]};

   assign lk_idx = IF_PC[INDEX_W+1:2];
   assign lk_tag = IF_PC[ADDR_W-1:INDEX_W+2];
   assign up_idx = Upd_pc[INDEX_W+1:2];
   assign up_tag = Upd_pc[ADDR_W-1:INDEX_W+2];

   assign Pred_hit    = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
   assign Pred_taken  = Pred_hit && ctr_mem[lk_idx][1];
   assign Pred_target = Pred_hit ? target_mem[lk_idx] : '0;

   assign Mispredict = Upd_valid &&
                       ((Upd_taken != Upd_pred_taken) ||
                        (Upd_taken && (Upd_target != Upd_pred_target)));

   assign up_hit = valid[up_idx] && (tag_mem[up_idx] == up_tag);

   sat_counter2 u_ctr (
      .cur   (ctr_mem[up_idx]),
      .taken (Upd_taken),
      .nxt   (ctr_nxt)
   );

   // Lookup reads the pre-edge table, so a same-index update shows up one cycle later.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_mem[i]    <= '0;
            target_mem[i] <= '0;
            ctr_mem[i]    <= CTR_RESET;
         end
      end else if (Flush_all) begin
         valid <= '0;
      end else if (Upd_valid) begin
         if (up_hit) begin
            ctr_mem[up_idx] <= ctr_nxt;
            if (Upd_taken) begin
               target_mem[up_idx] <= Upd_target;
            end
         end else if (Upd_taken) begin
            valid[up_idx]      <= 1'b1;
            tag_mem[up_idx]    <= up_tag;
            target_mem[up_idx] <= Upd_target;
            ctr_mem[up_idx]    <= CTR_INIT;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Hit_cnt     <= '0;
         Mispred_cnt <= '0;
      end else begin
         if (Pred_hit && (Hit_cnt != '1)) begin
            Hit_cnt <= Hit_cnt + STAT_W'(1);
         end
         if (Mispredict && (Mispred_cnt != '1)) begin
            Mispred_cnt <= Mispred_cnt + STAT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised successor to the fixed single-entry branch target buffer in the IF stage.
- Direct-mapped, N-entry BTB with tag match, per-entry 2-bit saturating direction counters, and a registered update path from the ID-stage branch resolution (Branch_calc / Branch address adder).
- Gives IF a same-cycle taken/target prediction and reports mispredictions back to the hazard logic for flush.
- Keeps saturating hit and mispredict statistics.

Parameters:
- ADDR_W, 32: PC / target width.
- INDEX_W, 4: index bits; ENTRIES = 2**INDEX_W.
- STAT_W, 16: width of statistics counters.
- Derived (localparam) TAG_W = ADDR_W - INDEX_W - 2.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IF_PC  in  ADDR_W  fetch PC for lookup.
- Pred_hit  out  1  valid entry with matching tag for IF_PC.
- Pred_taken  out  1  predicted taken (Pred_hit && counter MSB).
- Pred_target  out  ADDR_W  stored target; 0 when Pred_hit=0.
- Upd_valid  in  1  ID resolved a conditional branch this cycle.
- Upd_pc  in  ADDR_W  PC of resolved branch.
- Upd_taken  in  1  actual outcome.
- Upd_target  in  ADDR_W  actual target (ID_PC_4 + offset<<2).
- Upd_pred_taken  in  1  prediction carried down with the instruction.
- Upd_pred_target  in  ADDR_W  predicted target carried down.
- Mispredict  out  1  combinational; see below.
- Flush_all  in  1  invalidate entire table next edge.
- Hit_cnt  out  STAT_W  lookups with Pred_hit=1.
- Mispred_cnt  out  STAT_W  Mispredict events.

Behaviour:
- Indexing: idx = PC[INDEX_W+1:2], tag = PC[ADDR_W-1:INDEX_W+2]. PC[1:0] is ignored.
- Lookup is purely combinational from IF_PC and the current table state. It has zero latency.
- Counter states, 2-bit: SN=00, WN=01, WT=10, ST=11. Predict taken when MSB=1.
- Mispredict = Upd_valid && (Upd_taken != Upd_pred_taken || (Upd_taken && Upd_target != Upd_pred_target)).
- Update at the CLK edge when Upd_valid=1 and Flush_all=0:
  - Tag hit, taken: ctr saturating increment (ST stays ST); target <= Upd_target.
  - Tag hit, not taken: ctr saturating decrement (SN stays SN); target unchanged.
  - Miss/invalid, taken: allocate and overwrite. valid=1, tag, target=Upd_target, ctr=WT.
  - Miss/invalid, not taken: no allocation; table unchanged.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. There is no bypass, and the new state is visible the next cycle.
- Flush_all=1: all valid bits are cleared at the next edge. A simultaneous update is discarded, but Mispredict and Mispred_cnt still count it.
- Statistics:
  - Hit_cnt increments by 1 on each edge where Pred_hit=1.
  - Mispred_cnt increments by 1 on each edge where Mispredict=1.
  - Both saturate at all-ones, neither wraps, and only RESET clears them.
- RESET low, asynchronous, including mid-operation:
  - all valid=0, ctr=WN, tag/target=0;
  - Hit_cnt=0, Mispred_cnt=0;
  - hence Pred_hit=0, Pred_taken=0, Pred_target=0.
  - Mispredict depends only on inputs.
- Upd_valid=0: no table change; Mispredict=0.
- Unaligned Upd_pc aliases to its word address. This is acceptable.

Decomposition:
- Shared package btb_pkg holds:
  - counter state localparams SN/WN/WT/ST;
  - CTR_INIT (WT) and CTR_RESET (WN);
  - functions ctr_inc_sat and ctr_dec_sat.
- One sub-module, sat_counter2: 2-bit next-state logic (inputs cur, taken; output nxt), instantiated per update path, not per entry.
- Storage is flip-flop arrays in btb_predictor (valid, tag, target, ctr).

Test Plan:
- Reset then lookup IF_PC=0x00400010 -> Pred_hit=0, Pred_taken=0, Pred_target=0, counters 0.
- Update pc=0x00400010 taken target=0x00400040, pred_taken=0 -> Mispredict=1. Next cycle lookup -> hit=1, taken=1, target=0x00400040 (ctr WT), Mispred_cnt=1.
- Two not-taken updates to the same pc -> ctr WT→WN→SN, Pred_taken=0, Pred_hit=1. Further not-taken keeps SN. Three taken updates reach ST, and more stay ST.
- Aliasing: pc 0x00400010 then taken update at 0x00400050 (same idx, different tag) -> entry replaced; lookup 0x00400010 -> hit=0.
- Same-cycle lookup+update same index -> old values this cycle, new values next. Flush_all with simultaneous update -> all hits 0 next cycle, update dropped, Mispred_cnt still increments.
- STAT_W=4 build: 20 hit cycles -> Hit_cnt=15 and holds. Assert RESET low mid-run, asynchronously between edges -> outputs 0 immediately.
